// File: rtl/vip_pkg.sv
// Shared types and helpers for the VIP 3x3 window sequencing logic.
// Holds the controller state encoding, a width helper and border flag bit positions.
package vip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        GAP,
        FLUSH
    } vip_state_t;

    // Bit positions inside the {top, bottom, left, right} border vector
    localparam int unsigned BORDER_TOP    = 3;
    localparam int unsigned BORDER_BOTTOM = 2;
    localparam int unsigned BORDER_LEFT   = 1;
    localparam int unsigned BORDER_RIGHT  = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vip_delay_line.sv
// Fixed-depth register shift used to align sync, valid and coordinates with
// the line-buffer tap latency.
module vip_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/matrix_window_ctrl.sv
// Sequencing controller for the 3-row line buffer: primes on input row 0,
// regenerates a synthetic last line, and emits latency-aligned sync/coords/borders.
module matrix_window_ctrl
    import vip_pkg::*;
#(
    parameter int unsigned IMG_HDISP  = 640,
    parameter int unsigned IMG_VDISP  = 480,
    parameter int unsigned LB_LATENCY = 3,
    parameter int unsigned FLUSH_GAP  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pre_frame_vsync,
    input  logic                          pre_frame_href,
    input  logic                          pre_frame_clken,
    output logic                          lb_href,
    output logic                          lb_clken,
    output logic                          flush_active,
    output logic                          post_frame_vsync,
    output logic                          post_frame_href,
    output logic                          post_frame_clken,
    output logic [clog2(IMG_HDISP)-1:0]   post_col,
    output logic [clog2(IMG_VDISP)-1:0]   post_row,
    output logic [3:0]                    border,
    output logic                          line_len_err
);

    localparam int unsigned CW = clog2(IMG_HDISP);
    localparam int unsigned RW = clog2(IMG_VDISP);
    localparam int unsigned GW = clog2(FLUSH_GAP + 1);
    localparam int unsigned DW = 3 + CW + RW;

    vip_state_t    r_state;
    vip_state_t    w_next;
    logic          r_vsync_d;
    logic          r_lb_href_d;
    logic [CW-1:0] r_in_col;
    logic          r_col_full;
    logic          r_col_over;
    logic [RW-1:0] r_in_row;
    logic [GW-1:0] r_gap_cnt;
    logic          r_len_err;

    logic          w_vs_rise;
    logic          w_pass;
    logic          w_emit;
    logic          w_fall;
    logic          w_last_row;
    logic          w_len_ok;
    logic          w_vs_gate;
    logic          w_fwd_clken;
    logic [RW-1:0] w_out_row;
    logic [DW-1:0] w_pipe_in;
    logic [DW-1:0] w_pipe_out;

    always_comb begin
        w_next       = r_state;
        w_pass       = (r_state == PRIME) || (r_state == RUN);
        w_emit       = (r_state == RUN) || (r_state == FLUSH);
        flush_active = (r_state == FLUSH);
        lb_href      = w_pass ? pre_frame_href : flush_active;
        lb_clken     = w_pass ? (pre_frame_clken & pre_frame_href) : flush_active;
        w_vs_rise    = pre_frame_vsync & ~r_vsync_d;
        w_fall       = w_pass & r_lb_href_d & ~lb_href;
        w_last_row   = (r_state == RUN) && (r_in_row == RW'(IMG_VDISP - 1));
        w_len_ok     = r_col_full & ~r_col_over;

        case (r_state)
            IDLE:  w_next = IDLE;
            PRIME: if (w_fall) w_next = RUN;
            RUN:   if (w_fall && w_last_row) w_next = GAP;
            GAP:   if (r_gap_cnt == GW'(FLUSH_GAP - 1)) w_next = FLUSH;
            FLUSH: if (r_in_col == CW'(IMG_HDISP - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_vs_rise) begin
            w_next = PRIME;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_vsync_d   <= 1'b0;
            r_lb_href_d <= 1'b0;
            r_in_col    <= '0;
            r_col_full  <= 1'b0;
            r_col_over  <= 1'b0;
            r_in_row    <= '0;
            r_gap_cnt   <= '0;
            r_len_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_vsync_d   <= pre_frame_vsync;
            // Cleared on restart so a line in flight at FLUSH/RUN cannot look like a PRIME line end
            r_lb_href_d <= lb_href & ~w_vs_rise;
            if (w_vs_rise || !lb_href) begin
                r_in_col   <= '0;
                r_col_full <= 1'b0;
                r_col_over <= 1'b0;
            end else if (lb_clken) begin
                if (r_col_full) begin
                    r_col_over <= 1'b1;
                end else if (r_in_col == CW'(IMG_HDISP - 1)) begin
                    r_col_full <= 1'b1;
                end else begin
                    r_in_col <= r_in_col + CW'(1);
                end
            end
            if (w_vs_rise) begin
                r_in_row <= '0;
            end else if (w_fall && !w_last_row) begin
                r_in_row <= r_in_row + RW'(1);
            end
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + GW'(1) : '0;
            r_len_err <= w_fall & ~w_vs_rise & ~w_len_ok;
        end
    end

    assign line_len_err = r_len_err;
    assign w_out_row    = flush_active ? RW'(IMG_VDISP - 1) : r_in_row - RW'(1);
    assign w_vs_gate    = pre_frame_vsync & ((r_state != IDLE) | w_vs_rise);
    // Pixels past the last column saturate and are never forwarded
    assign w_fwd_clken  = lb_clken & w_emit & ~r_col_full;
    assign w_pipe_in    = {w_vs_gate, w_fwd_clken, lb_href & w_emit, r_in_col, w_out_row};

    vip_delay_line #(
        .WIDTH (DW),
        .DEPTH (LB_LATENCY)
    ) u_align (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_data (w_pipe_in),
        .o_data (w_pipe_out)
    );

    assign {post_frame_vsync, post_frame_clken, post_frame_href, post_col, post_row} = w_pipe_out;

    always_comb begin
        border = '0;
        if (post_frame_clken) begin
            border[BORDER_TOP]    = (post_row == '0);
            border[BORDER_BOTTOM] = (post_row == RW'(IMG_VDISP - 1));
            border[BORDER_LEFT]   = (post_col == '0);
            border[BORDER_RIGHT]  = (post_col == CW'(IMG_HDISP - 1));
        end
    end

endmodule

// File: tb/tb_matrix_window_ctrl.sv
// Directed bench for matrix_window_ctrl on an 8x4 frame: counts, latency,
// coordinates, borders, short lines, restart, reset mid-flush and gapped pixels.
module tb_matrix_window_ctrl;

    localparam int unsigned H   = 8;
    localparam int unsigned V   = 4;
    localparam int unsigned LAT = 3;
    localparam int unsigned FG  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic       href  = 1'b0;
    logic       clken = 1'b0;
    logic       lb_href, lb_clken, flush_active;
    logic       pvs, phref, pclk;
    logic [2:0] pcol;
    logic [1:0] prow;
    logic [3:0] border;
    logic       lerr;

    always #5 clock = ~clock;

    matrix_window_ctrl #(
        .IMG_HDISP  (H),
        .IMG_VDISP  (V),
        .LB_LATENCY (LAT),
        .FLUSH_GAP  (FG)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .pre_frame_vsync  (vsync),
        .pre_frame_href   (href),
        .pre_frame_clken  (clken),
        .lb_href          (lb_href),
        .lb_clken         (lb_clken),
        .flush_active     (flush_active),
        .post_frame_vsync (pvs),
        .post_frame_href  (phref),
        .post_frame_clken (pclk),
        .post_col         (pcol),
        .post_row         (prow),
        .border           (border),
        .line_len_err     (lerr)
    );

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int pc_q[$];
    int pr_q[$];
    int pcol_q[$];
    int pb_q[$];
    int n_flush = 0;
    int n_err = 0;
    int pvs_cyc = -1;
    logic pvs_d = 1'b0;
    int rs[4];
    int vs_drive = 0;
    int restart_cyc = 0;
    int found;

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        #1;
        if (pclk) begin
            pc_q.push_back(cyc);
            pr_q.push_back(int'(prow));
            pcol_q.push_back(int'(pcol));
            pb_q.push_back(int'(border));
        end
        if (flush_active) n_flush++;
        if (lerr) n_err++;
        if (pvs && !pvs_d && pvs_cyc < 0) pvs_cyc = cyc;
        pvs_d = pvs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        pc_q.delete();
        pr_q.delete();
        pcol_q.delete();
        pb_q.delete();
        n_flush = 0;
        n_err   = 0;
        pvs_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            href  = 1'b0;
            clken = 1'b0;
        end
    endtask

    task automatic vs_pulse();
        @(negedge clock);
        vsync    = 1'b1;
        vs_drive = cyc;
        repeat (2) @(negedge clock);
        vsync = 1'b0;
        idle(2);
    endtask

    task automatic line(input int npix, input bit gapped, output int start);
        start = 0;
        for (int i = 0; i < npix; i++) begin
            @(negedge clock);
            href  = 1'b1;
            clken = 1'b1;
            if (i == 0) start = cyc;
            if (gapped && i != npix - 1) begin
                @(negedge clock);
                clken = 1'b0;
            end
        end
        idle(4);
    endtask

    task automatic frame(input int short_row, input bit gapped, input int nrows);
        vs_pulse();
        for (int r = 0; r < nrows; r++) begin
            line((r == short_row) ? H - 1 : H, gapped, rs[r]);
        end
    endtask

    task automatic drain();
        idle(FG + H + LAT + 6);
    endtask

    initial begin
        idle(3);
        chk("reset_outputs", {lb_href, lb_clken, flush_active, pvs, phref, pclk, pcol, prow, border, lerr}, 0);
        reset = 1'b0;
        idle(3);

        // Normal frame
        clr_log();
        frame(-1, 1'b0, 4);
        drain();
        chk("t1_count", pc_q.size(), 32);
        chk("t1_first_latency", pc_q[0], rs[1] + 3);
        chk("t1_vsync_latency", pvs_cyc, vs_drive + 3);
        for (int i = 0; i < 32; i++) begin
            chk("t1_coord", pr_q[i] * 16 + pcol_q[i], (i / 8) * 16 + (i % 8));
        end
        chk("t1_flush_cycles", n_flush, 8);
        chk("t1_border_r0c0", pb_q[0], 4'b1010);
        chk("t1_border_r3c7", pb_q[31], 4'b0101);
        chk("t1_border_r1c3", pb_q[11], 4'b0000);
        chk("t1_no_len_err", n_err, 0);

        // Input row 2 one pixel short
        clr_log();
        frame(2, 1'b0, 4);
        drain();
        chk("t2_count", pc_q.size(), 31);
        chk("t2_len_err", n_err, 1);
        chk("t2_row1_last", pr_q[14] * 16 + pcol_q[14], 1 * 16 + 6);
        chk("t2_row2_first", pr_q[15] * 16 + pcol_q[15], 2 * 16 + 0);
        chk("t2_flush_row", pr_q[30] * 16 + pcol_q[30], 3 * 16 + 7);
        chk("t2_flush_cycles", n_flush, 8);

        // Restart while RUN at input row 2
        clr_log();
        frame(-1, 1'b0, 2);
        restart_cyc = cyc;
        frame(-1, 1'b0, 4);
        drain();
        chk("t3_count", pc_q.size(), 40);
        chk("t3_resume_latency", pc_q[8], rs[1] + 3);
        chk("t3_resume_coord", pr_q[8] * 16 + pcol_q[8], 0);
        chk("t3_last_coord", pr_q[39] * 16 + pcol_q[39], 3 * 16 + 7);
        chk("t3_flush_cycles", n_flush, 8);

        // Reset asserted mid-FLUSH for 2 cycles
        clr_log();
        frame(-1, 1'b0, 4);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clock);
            found = int'(flush_active);
        end
        chk("t4_flush_seen", found, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("t4_reset_outputs", {lb_href, lb_clken, flush_active, pvs, phref, pclk, pcol, prow, border, lerr}, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clr_log();
        idle(30);
        chk("t4_quiet_pulses", pc_q.size(), 0);
        chk("t4_quiet_flush", n_flush, 0);
        clr_log();
        frame(-1, 1'b0, 4);
        drain();
        chk("t4_recover_count", pc_q.size(), 32);

        // One pixel every 2 cycles
        clr_log();
        frame(-1, 1'b1, 4);
        drain();
        chk("t5_count", pc_q.size(), 32);
        chk("t5_no_len_err", n_err, 0);
        chk("t5_first_latency", pc_q[0], rs[1] + 3);
        for (int i = 0; i < 32; i++) begin
            chk("t5_coord", pr_q[i] * 16 + pcol_q[i], (i / 8) * 16 + (i % 8));
        end
        for (int i = 1; i < 24; i++) begin
            if (i % 8 != 0) chk("t5_spacing", pc_q[i] - pc_q[i-1], 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_window_ctrl.md
Name: matrix_window_ctrl

Overview:
- Sequencing controller for the 3-row, 1-column line-buffer datapath used by the 3x3 VIP filters. It sits between the frame source and the line buffer, and between the line buffer and the filter kernel.
- Gates the buffer's enable and line-valid inputs, tracks pixel column and row, and hides the first input line while the buffer primes.
- Regenerates a final synthetic line so that the last image row gets a window.
- Emits latency-aligned output sync, coordinates and border flags so the kernel can replicate edge pixels.

Parameters:
- IMG_HDISP, 640, active pixels per line.
- IMG_VDISP, 480, active lines per frame.
- LB_LATENCY, 3, cycles from line-buffer clken to valid taps.
- FLUSH_GAP, 16, idle cycles between the last input line ending and the synthetic flush line starting.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pre_frame_vsync  in  1  frame sync; rising edge starts a frame.
- pre_frame_href  in  1  line valid.
- pre_frame_clken  in  1  pixel valid.
- lb_href  out  1  line valid to the line buffer.
- lb_clken  out  1  pixel enable to the line buffer.
- flush_active  out  1  high during the synthetic line; datapath muxes the line-buffer input to its previous-row tap.
- post_frame_vsync  out  1  frame sync aligned to the window.
- post_frame_href  out  1  window line valid.
- post_frame_clken  out  1  window pixel valid.
- post_col  out  clog2(IMG_HDISP)  column of the window centre.
- post_row  out  clog2(IMG_VDISP)  row of the window centre.
- border  out  4  {top, bottom, left, right} edge flags.
- line_len_err  out  1  one-cycle pulse when an input line length is not IMG_HDISP.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset mid-frame abandons the frame; nothing is emitted until the next vsync rising edge.
- States:
  - IDLE: wait for a vsync rising edge, then go to PRIME.
  - PRIME: input row 0 only; lb_* pass through; post_* held low. On href falling, go to RUN.
  - RUN: input rows 1..IMG_VDISP-1. Output row k = input row - 1. On href falling with in_row == IMG_VDISP-1, go to GAP.
  - GAP: count FLUSH_GAP cycles, then go to FLUSH.
  - FLUSH: drive lb_href = 1, lb_clken = 1 and flush_active = 1 for exactly IMG_HDISP consecutive cycles. This line produces output row IMG_VDISP-1. Then go to IDLE.
- Vsync rising edge in any state other than IDLE: clear counters, go to PRIME, and drop any in-flight GAP/FLUSH. Already-issued delayed post_* pulses still drain.
- Pass-through: lb_href = pre_frame_href and lb_clken = pre_frame_clken & pre_frame_href in PRIME/RUN; combinational, no added latency.
- in_col increments on each lb_clken and clears when lb_href is low. in_row increments on each lb_href falling edge and clears on vsync rising.
- Line-length check: on an input href falling edge, if in_col != IMG_HDISP, pulse line_len_err for 1 cycle. The row still counts. Columns beyond IMG_HDISP-1 saturate and are not forwarded to post_clken.
- Output alignment: post_frame_clken, post_frame_href, post_col and post_row come from a LB_LATENCY-deep shift of {lb_clken & emit, lb_href & emit, in_col, out_row}.
  - emit = (state RUN or FLUSH).
  - Total latency from lb_clken to post_frame_clken is exactly LB_LATENCY cycles.
- post_frame_vsync: the input vsync delayed by LB_LATENCY. Held low in IDLE after flush completion until the next input vsync.
- Border flags (from delayed coordinates; meaningful only when post_frame_clken = 1):
  - top = (post_row == 0)
  - bottom = (post_row == IMG_VDISP-1)
  - left = (post_col == 0)
  - right = (post_col == IMG_HDISP-1)
- Input href asserted during GAP or FLUSH (source violates blanking): ignore the input; no counting and no error.
- Simultaneous href falling and vsync rising: the vsync restart wins.
- Counter widths are clog2(IMG_*); there is no wrap-around inside legal frames.

Decomposition:
- Shared package vip_pkg: state enum {IDLE, PRIME, RUN, GAP, FLUSH}, the clog2 function, and the border bit-index constants.
- One sub-module, vip_delay_line (parameterised WIDTH and DEPTH register shift), used for the LB_LATENCY alignment pipe. Rest is flat.

Test Plan:
- 8x4 frame (IMG_HDISP=8, IMG_VDISP=4), contiguous href, 4 idle cycles between lines:
  - 32 post_frame_clken pulses.
  - The first pulse comes 3 cycles after the first clken of input row 1.
  - Rows 0..3; the final row is produced by FLUSH with flush_active high for 8 cycles.
- Same frame, check flags:
  - border = 4'b1010 at (row 0, col 0).
  - border = 4'b0101 at (row 3, col 7).
  - border = 0 at interior (row 1, col 3).
- Input row 2 of the 8x4 frame has 7 pixels: line_len_err pulses once at its href falling edge; post_row still advances to 3 in FLUSH.
- Vsync rising during RUN at input row 2: state becomes PRIME; no further post_frame_clken until the new frame's row 1; the new frame outputs 32 pixels.
- Reset asserted mid-FLUSH for 2 cycles:
  - All outputs 0 the cycle after reset is sampled.
  - flush_active stays low.
  - Nothing is emitted until the next vsync.
- Gapped clken (one pixel every 2 cycles):
  - post_col sequence 0..7 with the same gaps, each 3 cycles late.
  - 32 total pulses; no line_len_err.
